// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-outstanding load/store master with alignment checks and read timeout
// Byte/half/word accesses are mapped onto a 32-bit strobed memory bus.

module mem_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqVld,
  output logic        ReqRdy,
  input  logic        ReqWr,
  input  logic [31:0] ReqAddr,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqWData,
  output logic        RspVld,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic        RRdy,
  input  logic        RVld,
  output logic [31:0] RAddr,
  output logic [31:0] RWData,
  output logic        RWEn,
  output logic [3:0]  RWStrobe,
  input  logic [31:0] RData
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic [31:0] addr, wdata, rsp_data;
  logic [1:0]  size;
  logic        uns, rsp_err;
  logic [CW-1:0] cnt;

  logic        misalign, timeout_hit;
  logic [31:0] lane, load_val, wr_lane;
  logic [3:0]  wr_strb;

  assign misalign = (ReqSize == 2'b11) ||
                    (ReqSize == 2'b01 && ReqAddr[0]) ||
                    (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Bring the addressed lane down to bit 0 before size truncation and extension.
  assign lane = RData >> {addr[1:0], 3'b000};

  always_comb begin
    load_val = 32'h0;
    wr_lane  = 32'h0;
    wr_strb  = 4'h0;
    case (size)
      2'b00: begin
        load_val = uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        wr_lane  = {4{wdata[7:0]}};
        wr_strb  = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        load_val = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        wr_lane  = {2{wdata[15:0]}};
        wr_strb  = 4'b0011 << {addr[1], 1'b0};
      end
      2'b10: begin
        load_val = lane;
        wr_lane  = wdata;
        wr_strb  = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ReqRdy   = 1'b0;
    RRdy     = 1'b0;
    RWEn     = 1'b0;
    RspVld   = 1'b0;
    case (state)
      IDLE: begin
        ReqRdy = 1'b1;
        if (ReqVld) begin
          if (misalign)   state_nx = RESP;
          else if (ReqWr) state_nx = WR;
          else            state_nx = RD;
        end
      end
      RD: begin
        RRdy = 1'b1;
        if (RVld || timeout_hit) state_nx = RESP;
      end
      WR: begin
        RWEn     = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        RspVld   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Outputs are silenced combinationally so an aborted access never reaches the bus.
    if (rst) begin
      state_nx = IDLE;
      ReqRdy   = 1'b0;
      RRdy     = 1'b0;
      RWEn     = 1'b0;
      RspVld   = 1'b0;
    end
  end

  assign RAddr    = (RRdy || RWEn) ? {addr[31:2], 2'b00} : 32'h0;
  assign RWData   = RWEn ? wr_lane : 32'h0;
  assign RWStrobe = RWEn ? wr_strb : 4'h0;
  assign RspData  = RspVld ? rsp_data : 32'h0;
  assign RspErr   = RspVld & rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= 32'h0;
      wdata    <= 32'h0;
      size     <= 2'b00;
      uns      <= 1'b0;
      rsp_data <= 32'h0;
      rsp_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ReqVld) begin
            addr     <= ReqAddr;
            wdata    <= ReqWData;
            size     <= ReqSize;
            uns      <= ReqUnsigned;
            rsp_data <= 32'h0;
            rsp_err  <= misalign;
          end
        end
        RD: begin
          if (RVld) begin
            rsp_data <= load_val;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= 32'h0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed bench for mem_master against a strobed word memory model
// The responder returns one beat the cycle after RRdy unless respond_en is low.

module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqVld, ReqWr, ReqUnsigned;
  logic [31:0] ReqAddr, ReqWData;
  logic [1:0]  ReqSize;
  logic        ReqRdy, RspVld, RspErr;
  logic [31:0] RspData;
  logic        RRdy, RWEn;
  logic        RVld;
  logic [31:0] RAddr, RWData;
  logic [3:0]  RWStrobe;
  logic [31:0] RData;

  logic [31:0] mem [0:255];
  logic        respond_en;

  int vectors = 0;
  int miscompares = 0;

  int          t_lat, t_rrdy, t_wen;
  logic [31:0] t_raddr, t_wdata, t_data;
  logic [3:0]  t_strb;
  logic        t_err, saw;

  mem_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ReqVld(ReqVld), .ReqRdy(ReqRdy), .ReqWr(ReqWr), .ReqAddr(ReqAddr),
    .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqWData(ReqWData),
    .RspVld(RspVld), .RspData(RspData), .RspErr(RspErr),
    .RRdy(RRdy), .RVld(RVld), .RAddr(RAddr), .RWData(RWData),
    .RWEn(RWEn), .RWStrobe(RWStrobe), .RData(RData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) RVld <= 1'b0;
    else     RVld <= RRdy && !RVld && respond_en;
    RData <= mem[RAddr[9:2]];
    if (RWEn)
      for (int b = 0; b < 4; b++)
        if (RWStrobe[b]) mem[RAddr[9:2]][8*b +: 8] <= RWData[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and record bus activity up to and including the response pulse.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd);
    @(negedge clk);
    ReqVld = 1'b1; ReqWr = wr; ReqAddr = a; ReqSize = sz; ReqUnsigned = u; ReqWData = wd;
    @(posedge clk);
    #1 ReqVld = 1'b0;
    t_lat = 999; t_rrdy = 0; t_wen = 0;
    t_raddr = 32'h0; t_wdata = 32'h0; t_strb = 4'h0; t_data = 32'hx; t_err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (RRdy) begin t_rrdy++; t_raddr = RAddr; end
      if (RWEn) begin t_wen++; t_raddr = RAddr; t_wdata = RWData; t_strb = RWStrobe; end
      if (RspVld) begin t_lat = k; t_data = RspData; t_err = RspErr; break; end
    end
  endtask

  initial begin
    rst = 1'b1; ReqVld = 1'b0; ReqWr = 1'b0; ReqAddr = 32'h0; ReqSize = 2'b00;
    ReqUnsigned = 1'b0; ReqWData = 32'h0; respond_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_reqrdy", {31'h0, ReqRdy}, 32'h0);
    chk("rst_rspvld", {31'h0, RspVld}, 32'h0);
    chk("rst_rrdy",   {31'h0, RRdy}, 32'h0);
    chk("rst_rwen",   {31'h0, RWEn}, 32'h0);
    chk("rst_raddr",  RAddr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_reqrdy", {31'h0, ReqRdy}, 32'h1);

    do_req(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF);
    chk("sw_wen",   t_wen, 1);
    chk("sw_rrdy",  t_rrdy, 0);
    chk("sw_raddr", t_raddr, 32'h100);
    chk("sw_strb",  {28'h0, t_strb}, 32'hF);
    chk("sw_wdata", t_wdata, 32'hDEADBEEF);
    chk("sw_lat",   t_lat, 2);
    chk("sw_err",   {31'h0, t_err}, 32'h0);
    chk("sw_data",  t_data, 32'h0);

    do_req(1'b1, 32'h100, 2'b10, 1'b0, 32'h80FF1234);
    chk("sw2_lat", t_lat, 2);

    do_req(1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
    chk("lbs_data",  t_data, 32'hFFFFFF80);
    chk("lbs_lat",   t_lat, 3);
    chk("lbs_rrdy",  t_rrdy, 2);
    chk("lbs_raddr", t_raddr, 32'h100);
    chk("lbs_err",   {31'h0, t_err}, 32'h0);

    do_req(1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
    chk("lbu_data", t_data, 32'h00000080);
    chk("lbu_lat",  t_lat, 3);

    do_req(1'b1, 32'h102, 2'b01, 1'b0, 32'h0000ABCD);
    chk("sh_wdata", t_wdata, 32'hABCDABCD);
    chk("sh_strb",  {28'h0, t_strb}, 32'hC);
    chk("sh_raddr", t_raddr, 32'h100);

    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    chk("lw_data",  t_data, 32'hABCD1234);
    chk("lw_upper", {16'h0, t_data[31:16]}, 32'h0000ABCD);

    do_req(1'b0, 32'h102, 2'b01, 1'b0, 32'h0);
    chk("lhs_data", t_data, 32'hFFFFABCD);
    do_req(1'b0, 32'h102, 2'b01, 1'b1, 32'h0);
    chk("lhu_data", t_data, 32'h0000ABCD);

    do_req(1'b1, 32'h101, 2'b00, 1'b0, 32'h0000005A);
    chk("sb_wdata", t_wdata, 32'h5A5A5A5A);
    chk("sb_strb",  {28'h0, t_strb}, 32'h2);
    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    chk("sb_merge", t_data, 32'hABCD5A34);

    do_req(1'b0, 32'h101, 2'b10, 1'b0, 32'h0);
    chk("mw_lat", t_lat, 1);
    chk("mw_err", {31'h0, t_err}, 32'h1);
    chk("mw_data", t_data, 32'h0);
    chk("mw_bus", t_rrdy + t_wen, 0);
    do_req(1'b1, 32'h001, 2'b01, 1'b0, 32'h1234);
    chk("mh_lat", t_lat, 1);
    chk("mh_err", {31'h0, t_err}, 32'h1);
    chk("mh_bus", t_rrdy + t_wen, 0);
    do_req(1'b1, 32'h100, 2'b11, 1'b0, 32'h1234);
    chk("ms_lat", t_lat, 1);
    chk("ms_err", {31'h0, t_err}, 32'h1);
    chk("ms_bus", t_rrdy + t_wen, 0);

    respond_en = 1'b0;
    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    chk("to_rrdy", t_rrdy, 16);
    chk("to_lat",  t_lat, 17);
    chk("to_err",  {31'h0, t_err}, 32'h1);
    chk("to_data", t_data, 32'h0);
    @(negedge clk);
    chk("to_idle", {31'h0, ReqRdy}, 32'h1);

    @(negedge clk);
    ReqVld = 1'b1; ReqWr = 1'b0; ReqAddr = 32'h100; ReqSize = 2'b10; ReqUnsigned = 1'b0;
    @(posedge clk);
    #1 ReqVld = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_rrdy_mid", {31'h0, RRdy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rrdy_rst", {31'h0, RRdy}, 32'h0);
    rst = 1'b0;
    respond_en = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (RspVld || RRdy) saw = 1'b1;
    end
    chk("ab_no_rsp", {31'h0, saw}, 32'h0);
    chk("ab_reqrdy", {31'h0, ReqRdy}, 32'h1);
    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    chk("ab_after_data", t_data, 32'hABCD5A34);
    chk("ab_after_lat",  t_lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent waiting for RVld on a read before error.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ReqVld  input  1  client request valid.
REQ-005 SHALL have port ReqRdy  output  1  high = request accepted this cycle if ReqVld.
REQ-006 SHALL have port ReqWr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port ReqAddr  input  32  byte address.
REQ-008 SHALL have port ReqSize  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port ReqUnsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port ReqWData  input  32  store data, right-justified.
REQ-011 SHALL have port RspVld  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RspData  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port RspErr  output  1  valid with RspVld: misaligned, illegal size or timeout.
REQ-014 SHALL have bus ports RRdy out 1, RVld in 1, RAddr out 32, RWData out 32, RWEn out 1, RWStrobe out 4, RData in 32, matching the memory-model protocol.

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR, RESP; ReqRdy = 1 only in IDLE.
REQ-016 IDLE: on ReqVld & ReqRdy SHALL latch all Req* fields; next state RESP with error if misaligned, otherwise RD for a load or WR for a store.
REQ-017 Misalignment SHALL be half with ReqAddr[0]=1, word with ReqAddr[1:0]!=0, or size 11; no bus activity SHALL occur.
REQ-018 RAddr SHALL equal {addr[31:2],2'b00} in RD and WR, and 0 otherwise.
REQ-019 RD: RRdy SHALL be 1 every RD cycle; on RVld=1 SHALL capture RData and go to RESP, so RRdy is 0 the following cycle and the responder issues exactly one beat.
REQ-020 RD SHALL count wait cycles; after TIMEOUT cycles without RVld it SHALL go to RESP with RspErr=1 and RspData=0.
REQ-021 RVld while not in RD SHALL be ignored.
REQ-022 WR: RWEn SHALL be 1 for exactly one cycle with RRdy=0, then the FSM SHALL go to RESP.
REQ-023 RWData SHALL be {4{data[7:0]}} for byte, {2{data[15:0]}} for half, and data for word.
REQ-024 RWStrobe SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<{addr[1],1'b0} for half, and 4'b1111 for word; RWStrobe and RWData SHALL be 0 when RWEn=0.
REQ-025 Load result SHALL be the lane (RData >> 8*addr[1:0]) truncated to size, then sign- or zero-extended per the latched Unsigned bit.
REQ-026 RESP: RspVld SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; RspData/RspErr SHALL be 0 whenever RspVld=0.
REQ-027 Latency SHALL be: read with RVld one cycle after RRdy gives RspVld 3 cycles after acceptance; store gives RspVld 2 cycles after acceptance; error gives 1 cycle.
REQ-028 Only one request SHALL be outstanding; back-to-back requests SHALL be accepted only in IDLE.

Reset
REQ-029 While rst=1 the FSM SHALL go to IDLE, the counter and latched request SHALL clear, and all outputs SHALL be 0 except ReqRdy, which SHALL be 1 from the cycle after rst deasserts.
REQ-030 Reset asserted during RD or WR SHALL abort the transaction; no RspVld SHALL be produced for it, and RRdy/RWEn SHALL be 0 the next cycle.

Verification
REQ-031 Bench SHALL cover word store: addr 0x100, data 0xDEADBEEF, size 10 -> one-cycle RWEn, RAddr 0x100, RWStrobe 1111; RspVld 2 cycles later, RspErr=0.
REQ-032 Bench SHALL cover signed byte load: addr 0x103, RData 0x80FF1234 -> RspData 0xFFFFFF80; the same load with Unsigned=1 -> 0x00000080; RspVld 3 cycles after accept.
REQ-033 Bench SHALL cover half store: addr 0x102, data 0x0000ABCD -> RWData 0xABCDABCD, RWStrobe 1100; a following word load at 0x100 over the memory model returns the upper half 0xABCD.
REQ-034 Bench SHALL cover misaligned/illegal requests: word at 0x101, half at 0x1, size 11 -> RspVld with RspErr=1 one cycle after accept, RRdy and RWEn never asserted.
REQ-035 Bench SHALL cover timeout: responder holds RVld=0 -> RRdy high for exactly 16 cycles, then RspErr=1 with RspData=0, and IDLE is reentered.
REQ-036 Bench SHALL cover rst pulsed mid-RD -> no RspVld, RRdy=0 the next cycle, and a subsequent load completes normally.
